// File: rtl/aquarium_pump_sequencer.sv
// Aquarium pump sequencer: drives the hot and cold circulation pumps from
// heat/cool requests. It keeps the two pumps mutually exclusive, enforces
// minimum on time, dead time and maximum run time, and latches a dry-run
// lockout when the water level drops.
module aquarium_pump_sequencer #(
    parameter int TICK_DIV     = 50000000,
    parameter int MIN_ON_TICKS = 10,
    parameter int DEAD_TICKS   = 5,
    parameter int MAX_ON_TICKS = 600,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heat_req,
    input  logic       cool_req,
    input  logic       water_ok,
    input  logic       fault_clr,
    output logic       pump_hot,
    output logic       pump_cold,
    output logic       busy,
    output logic       conflict,
    output logic [1:0] fault_code,
    output logic [2:0] state_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MIN_T      = CNT_W'(MIN_ON_TICKS);
    localparam logic [CNT_W-1:0] DEAD_T     = CNT_W'(DEAD_TICKS);
    localparam logic [CNT_W-1:0] MAX_T      = CNT_W'(MAX_ON_TICKS);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_LOW_H2O = 2'b01;
    localparam logic [1:0] FC_OVERRUN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOT_ON  = 3'd1,
        S_COLD_ON = 3'd2,
        S_DEAD    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       fault_q, fault_d;
    logic             tick;
    logic             pump_hot_q, pump_cold_q, busy_q, conflict_q;

    // Free-running timebase; tick marks the last cycle of each period.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Next-state logic: water loss always wins, then overrun, then normal sequencing.
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (!water_ok) begin
                    state_d = S_LOCKOUT;
                    fault_d = FC_LOW_H2O;
                end else if (heat_req && !cool_req) begin
                    state_d = S_HOT_ON;
                end else if (cool_req && !heat_req) begin
                    state_d = S_COLD_ON;
                end
            end
            S_HOT_ON, S_COLD_ON: begin
                if (!water_ok) begin
                    state_d = S_LOCKOUT;
                    fault_d = FC_LOW_H2O;
                end else if (timer_q >= MAX_T) begin
                    state_d = S_LOCKOUT;
                    fault_d = FC_OVERRUN;
                end else if (timer_q >= MIN_T &&
                             !((state_q == S_HOT_ON) ? heat_req : cool_req)) begin
                    state_d = S_DEAD;
                end
            end
            S_DEAD: begin
                if (!water_ok) begin
                    state_d = S_LOCKOUT;
                    fault_d = FC_LOW_H2O;
                end else if (timer_q >= DEAD_T) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (fault_clr && water_ok) begin
                    state_d = S_IDLE;
                    fault_d = FC_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                fault_d = FC_NONE;
            end
        endcase
    end

    // State timer restarts on every state change and saturates at its maximum.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && (timer_q != '1)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // State, timers and outputs; outputs decode the next state so pumps move with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            timer_q     <= '0;
            fault_q     <= FC_NONE;
            pump_hot_q  <= 1'b0;
            pump_cold_q <= 1'b0;
            busy_q      <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            timer_q     <= timer_d;
            fault_q     <= fault_d;
            pump_hot_q  <= (state_d == S_HOT_ON);
            pump_cold_q <= (state_d == S_COLD_ON);
            busy_q      <= (state_d == S_HOT_ON) || (state_d == S_COLD_ON) ||
                           (state_d == S_DEAD);
            conflict_q  <= (state_d == S_IDLE) && heat_req && cool_req;
        end
    end

    assign pump_hot   = pump_hot_q;
    assign pump_cold  = pump_cold_q;
    assign busy       = busy_q;
    assign conflict   = conflict_q;
    assign fault_code = fault_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_aquarium_pump_sequencer.sv
// Scoreboard bench for aquarium_pump_sequencer: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a reference model that
// derives elapsed ticks from absolute cycle counts.
module tb_aquarium_pump_sequencer;

    localparam int TICK_DIV = 4;
    localparam int MIN_ON   = 3;
    localparam int DEAD_T   = 2;
    localparam int MAX_ON   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       heat_req = 1'b0, cool_req = 1'b0, water_ok = 1'b1, fault_clr = 1'b0;
    logic       pump_hot, pump_cold, busy, conflict;
    logic [1:0] fault_code;
    logic [2:0] state_o;

    aquarium_pump_sequencer #(
        .TICK_DIV(TICK_DIV), .MIN_ON_TICKS(MIN_ON), .DEAD_TICKS(DEAD_T),
        .MAX_ON_TICKS(MAX_ON), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .heat_req(heat_req), .cool_req(cool_req),
        .water_ok(water_ok), .fault_clr(fault_clr), .pump_hot(pump_hot),
        .pump_cold(pump_cold), .busy(busy), .conflict(conflict),
        .fault_code(fault_code), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ph;
        logic       pc;
        logic       bz;
        logic       cf;
        logic [1:0] fc;
        logic [2:0] st;
    } obs_t;

    obs_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: mode per the state_o numbering, entry cycle, fault.
    int m_mode  = 0;
    int m_fc    = 0;
    int m_cycle = 0;
    int m_entry = 0;

    task automatic model_step(input bit rn, input bit h, input bit c,
                              input bit w, input bit clr);
        obs_t e;
        int   ticks, nxt;
        if (!rn) begin
            m_mode = 0; m_fc = 0; m_cycle = 0; m_entry = 0;
            e = '0;
            sb.push_back(e);
            return;
        end
        // ticks elapsed since entry = number of period boundaries crossed
        ticks = (m_cycle / TICK_DIV) - (m_entry / TICK_DIV);
        nxt = m_mode;
        case (m_mode)
            0: if (!w) begin nxt = 4; m_fc = 1; end
               else if (h && !c) nxt = 1;
               else if (c && !h) nxt = 2;
            1, 2: begin
                if (!w) begin nxt = 4; m_fc = 1; end
                else if (ticks >= MAX_ON) begin nxt = 4; m_fc = 2; end
                else if (ticks >= MIN_ON && !((m_mode == 1) ? h : c)) nxt = 3;
            end
            3: if (!w) begin nxt = 4; m_fc = 1; end
               else if (ticks >= DEAD_T) nxt = 0;
            default: if (clr && w) begin nxt = 0; m_fc = 0; end
        endcase
        m_cycle++;
        if (nxt != m_mode) m_entry = m_cycle;
        m_mode = nxt;
        e.ph = (nxt == 1);
        e.pc = (nxt == 2);
        e.bz = (nxt == 1) || (nxt == 2) || (nxt == 3);
        e.cf = (nxt == 0) && h && c;
        e.fc = 2'(m_fc);
        e.st = 3'(nxt);
        sb.push_back(e);
    endtask

    task automatic cyc(input bit rn, input bit h, input bit c,
                       input bit w, input bit clr);
        @(negedge clk);
        rst_n = rn; heat_req = h; cool_req = c; water_ok = w; fault_clr = clr;
        model_step(rn, h, c, w, clr);
    endtask

    // Monitor: pop one expectation per clock and compare with what the DUT shows.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {pump_hot, pump_cold, busy, conflict, fault_code, state_o};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got ph=%b pc=%b busy=%b cf=%b fc=%b st=%0d want ph=%b pc=%b busy=%b cf=%b fc=%b st=%0d",
                             $time, a.ph, a.pc, a.bz, a.cf, a.fc, a.st,
                             e.ph, e.pc, e.bz, e.cf, e.fc, e.st);
                end
                if (pump_hot && pump_cold) begin
                    miscompares++;
                    $display("FAIL exclusion t=%0t got both pumps on, want at most one", $time);
                end
            end
        end
    end

    initial begin
        bit h, c, w, clr, rn;
        int guard;
        // 1: reset with all requests high
        repeat (2) cyc(0, 1, 1, 1, 0);
        // 2: one-cycle heat request, min-on hold, dead, idle
        cyc(1, 1, 0, 1, 0);
        repeat (30) cyc(1, 0, 0, 1, 0);
        // 3: changeover hot -> cold
        repeat (3) cyc(1, 1, 0, 1, 0);
        repeat (40) cyc(1, 0, 1, 1, 0);
        repeat (30) cyc(1, 0, 0, 1, 0);
        // 4: conflict then heat only
        repeat (5) cyc(1, 1, 1, 1, 0);
        repeat (5) cyc(1, 1, 0, 1, 0);
        repeat (30) cyc(1, 0, 0, 1, 0);
        // 5: low water during cold run, blocked clear, recovery, real clear
        repeat (6) cyc(1, 0, 1, 1, 0);
        repeat (3) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1);
        repeat (4) cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 1);
        repeat (4) cyc(1, 0, 0, 1, 0);
        // 6: overrun with heat held
        repeat (50) cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 0, 1, 1);
        repeat (4) cyc(1, 0, 0, 1, 0);
        // mid-run reset drops the pump on the same edge
        repeat (6) cyc(1, 1, 0, 1, 0);
        cyc(0, 1, 0, 1, 0);
        repeat (3) cyc(1, 0, 0, 1, 0);
        // randomized traffic
        h = 0; c = 0; w = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) h = ~h;
            if ($urandom_range(0, 9) == 0) c = ~c;
            w   = ($urandom_range(0, 59) != 0);
            clr = ($urandom_range(0, 11) == 0);
            rn  = ($urandom_range(0, 499) != 0);
            cyc(rn, h, c, w, clr);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
